// File: rtl/fmc_tx_datapath.sv
// DAC transmit datapath: per-channel pattern/ramp/zero muxing with a 1-cycle
// registered output, a synchronised external trigger with arm/holdoff FSM, and sticky over-range flags.
module fmc_tx_datapath #(
  parameter int NCH         = 4,
  parameter int DW          = 64,
  parameter int F           = 1,
  parameter int SYNC_STAGES = 2,
  parameter int HOLDOFF_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*DW-1:0]    dac_data_in,
  input  logic [NCH-1:0]       dac_valid_in,
  input  logic [2*NCH-1:0]     mode,
  output logic [NCH*DW-1:0]    dac_data_out,
  output logic [NCH-1:0]       dac_valid_out,
  input  logic                 ext_trig,
  input  logic                 trig_arm,
  input  logic [HOLDOFF_W-1:0] trig_holdoff,
  output logic                 trig_out,
  output logic [31:0]          trig_count,
  input  logic [2*NCH-1:0]     over_range,
  input  logic                 ovr_clear,
  output logic [2*NCH-1:0]     ovr_sticky
);

  // Octet k of the short test pattern is byte (k mod F) of this word.
  localparam logic [63:0]          PATTERN   = 64'h8097_A6B5_C4D3_E2F1;
  localparam logic [15:0]          RAMP_STEP = 16'(DW / 16);
  localparam logic [HOLDOFF_W-1:0] HOLD_ONE  = HOLDOFF_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_HOLDOFF = 2'd2
  } state_t;

  logic [15:0]          ramp_q [NCH];
  logic [NCH*DW-1:0]    data_d;
  logic [NCH-1:0]       valid_d;
  logic [SYNC_STAGES-1:0] trig_sync;
  logic                 trig_prev;
  logic                 trig_edge;
  logic [2*NCH-1:0]     ovr_sync [SYNC_STAGES];
  logic [HOLDOFF_W-1:0] hold_cnt;
  state_t               state_q;
  state_t               state_d;
  logic                 fire;

  always_comb begin
    data_d  = '0;
    valid_d = '0;
    for (int c = 0; c < NCH; c++) begin
      case (mode[2*c +: 2])
        2'd0: begin
          data_d[c*DW +: DW] = dac_data_in[c*DW +: DW];
          valid_d[c]         = dac_valid_in[c];
        end
        2'd1: begin
          for (int k = 0; k < DW/8; k++)
            data_d[c*DW + 8*k +: 8] = PATTERN[8*(k%F) +: 8];
          valid_d[c] = 1'b1;
        end
        2'd2: begin
          for (int j = 0; j < DW/16; j++)
            data_d[c*DW + 16*j +: 16] = ramp_q[c] + 16'(j);
          valid_d[c] = 1'b1;
        end
        default: valid_d[c] = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dac_data_out  <= '0;
      dac_valid_out <= '0;
    end else begin
      dac_data_out  <= data_d;
      dac_valid_out <= valid_d;
    end
  end

  // Ramp restarts from 0 whenever the channel leaves mode 2.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (rst || mode[2*c +: 2] != 2'd2) ramp_q[c] <= '0;
      else                               ramp_q[c] <= ramp_q[c] + RAMP_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      trig_sync <= '0;
      trig_prev <= 1'b0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], ext_trig};
      trig_prev <= trig_sync[SYNC_STAGES-1];
    end
  end

  assign trig_edge = trig_sync[SYNC_STAGES-1] & ~trig_prev;

  always_comb begin
    state_d = state_q;
    fire    = 1'b0;
    case (state_q)
      S_IDLE: if (trig_arm) state_d = S_ARMED;
      S_ARMED: begin
        // Disarm wins over a coincident edge.
        if (!trig_arm) state_d = S_IDLE;
        else if (trig_edge) begin
          fire    = 1'b1;
          state_d = S_HOLDOFF;
        end
      end
      S_HOLDOFF: if (hold_cnt == '0) state_d = trig_arm ? S_ARMED : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      hold_cnt   <= '0;
      trig_out   <= 1'b0;
      trig_count <= '0;
    end else begin
      state_q  <= state_d;
      trig_out <= fire;
      if (fire) begin
        trig_count <= trig_count + 32'd1;
        hold_cnt   <= trig_holdoff;
      end else if (state_q == S_HOLDOFF && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HOLD_ONE;
      end
    end
  end

  // A synchronised set outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) ovr_sync[s] <= '0;
      ovr_sticky <= '0;
    end else begin
      ovr_sync[0] <= over_range;
      for (int s = 1; s < SYNC_STAGES; s++) ovr_sync[s] <= ovr_sync[s-1];
      ovr_sticky <= (ovr_clear ? '0 : ovr_sticky) | ovr_sync[SYNC_STAGES-1];
    end
  end

endmodule
